// File: rtl/led_ctrl_pkg.sv
// Shared encodings and pattern constants for the running-light controller.
package led_ctrl_pkg;

  // Pattern modes, in the order the mode button cycles through them.
  localparam logic [1:0] MODE_SHL    = 2'd0;
  localparam logic [1:0] MODE_SHR    = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  // Sequencer states; 2'd3 is unused and recovers to idle.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  // Bounce direction.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic [7:0] PAT_SHL_INIT = 8'h01;
  localparam logic [7:0] PAT_SHR_INIT = 8'h80;
  localparam logic [7:0] PAT_BLINK_A  = 8'h55;
  localparam logic [7:0] PAT_BLINK_B  = 8'hAA;

  // First pattern shown after entering a mode.
  function automatic logic [7:0] pat_init(input logic [1:0] m);
    logic [7:0] p;
    case (m)
      MODE_SHL:    p = PAT_SHL_INIT;
      MODE_SHR:    p = PAT_SHR_INIT;
      MODE_BOUNCE: p = PAT_SHL_INIT;
      default:     p = PAT_BLINK_A;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-flop synchroniser, stability counter and
// a one-cycle pulse on each accepted press. Releases are accepted silently.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst,   // asynchronous, active-low
  input  logic i_btn,
  output logic o_rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_rise;
  logic          w_diff;
  logic          w_done;

  // The counter only runs while the synced sample disagrees with the accepted level.
  assign w_diff = r_sync[1] ^ r_level;
  assign w_done = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign o_rise = r_rise;

  // Synchronise, count consecutive differing samples, accept and flag rises.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync  <= 2'b00;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_rise <= w_done && r_sync[1];
      if (w_done) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/led_pattern_controller.sv
// Running-light sequencer: debounced start/mode/speed buttons, step-tick
// generator, idle/run/pause FSM and the LED pattern datapath.
module led_pattern_controller
  import led_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 100000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LED_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_start,
  input  logic             btn_mode,
  input  logic             btn_speed,
  output logic [LED_W-1:0] led,
  output logic             running,
  output logic [1:0]       mode,
  output logic [1:0]       speed
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV + 1);

  logic w_start_p, w_mode_p, w_speed_p;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .i_clk(clk), .i_rst(rst), .i_btn(btn_start), .o_rise(w_start_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .i_clk(clk), .i_rst(rst), .i_btn(btn_mode), .o_rise(w_mode_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_speed (
    .i_clk(clk), .i_rst(rst), .i_btn(btn_speed), .o_rise(w_speed_p)
  );

  logic [1:0]       r_state, r_mode, r_speed;
  logic [CNT_W-1:0] r_cnt;
  logic [LED_W-1:0] r_led;
  logic             r_dir;

  logic [1:0]       w_state_nx, w_mode_nx, w_speed_nx;
  logic [CNT_W-1:0] w_cnt_nx, w_div_last;
  logic [LED_W-1:0] w_led_nx, w_led_step;
  logic             w_dir_nx, w_dir_step;
  logic             w_last, w_tick, w_reload;

  // Each speed step halves the period.
  assign w_div_last = CNT_W'((TICK_DIV >> r_speed) - 1);
  assign w_last     = (r_cnt == w_div_last);
  // A mode or speed change swallows a coinciding tick.
  assign w_tick     = (r_state == ST_RUN) && w_last && !w_mode_p && !w_speed_p;
  assign w_reload   = ((r_state == ST_IDLE) && w_start_p) || ((r_state != ST_IDLE) && w_mode_p);

  assign led     = r_led;
  assign running = (r_state == ST_RUN);
  assign mode    = r_mode;
  assign speed   = r_speed;

  // One pattern step for the current mode.
  always_comb begin
    w_led_step = r_led;
    w_dir_step = r_dir;
    case (r_mode)
      MODE_SHL: w_led_step = {r_led[LED_W-2:0], r_led[LED_W-1]};
      MODE_SHR: w_led_step = {r_led[0], r_led[LED_W-1:1]};
      MODE_BOUNCE: begin
        if (r_dir == DIR_LEFT) begin
          if (r_led[LED_W-1]) begin
            w_led_step = r_led >> 1;
            w_dir_step = DIR_RIGHT;
          end else begin
            w_led_step = r_led << 1;
          end
        end else begin
          if (r_led[0]) begin
            w_led_step = r_led << 1;
            w_dir_step = DIR_LEFT;
          end else begin
            w_led_step = r_led >> 1;
          end
        end
      end
      default: begin
        w_led_step = (r_led == LED_W'(PAT_BLINK_A)) ? LED_W'(PAT_BLINK_B) : LED_W'(PAT_BLINK_A);
      end
    endcase
  end

  // Next state: mode/speed first, then FSM, counter and LED pattern.
  always_comb begin
    w_mode_nx  = r_mode + {1'b0, w_mode_p};
    w_speed_nx = r_speed + {1'b0, w_speed_p};

    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_p) w_state_nx = ST_RUN;
      ST_RUN:   if (w_start_p) w_state_nx = ST_PAUSE;
      ST_PAUSE: if (w_start_p) w_state_nx = ST_RUN;
      default:  w_state_nx = ST_IDLE;
    endcase

    w_cnt_nx = r_cnt;
    if ((r_state == ST_IDLE) || w_mode_p || w_speed_p) begin
      w_cnt_nx = '0;
    end else if (r_state == ST_RUN) begin
      w_cnt_nx = w_last ? '0 : r_cnt + CNT_W'(1);
    end

    w_led_nx = r_led;
    w_dir_nx = r_dir;
    if (w_reload) begin
      w_led_nx = LED_W'(pat_init(w_mode_nx));
      w_dir_nx = DIR_LEFT;
    end else if (w_tick) begin
      w_led_nx = w_led_step;
      w_dir_nx = w_dir_step;
    end
    if (w_state_nx == ST_IDLE) begin
      w_led_nx = '0;
      w_dir_nx = DIR_LEFT;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_SHL;
      r_speed <= 2'd0;
      r_cnt   <= '0;
      r_led   <= '0;
      r_dir   <= DIR_LEFT;
    end else begin
      r_state <= w_state_nx;
      r_mode  <= w_mode_nx;
      r_speed <= w_speed_nx;
      r_cnt   <= w_cnt_nx;
      r_led   <= w_led_nx;
      r_dir   <= w_dir_nx;
    end
  end

endmodule

// File: tb/tb_led_pattern_controller.sv
// Directed bench for led_pattern_controller with a cycle-level reference model.
module tb_led_pattern_controller;

  localparam int TD = 16;
  localparam int DB = 4;
  localparam int IDLE = 0;
  localparam int RUN = 1;
  localparam int PAUSE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_speed = 1'b0;
  logic [7:0] led;
  logic       running;
  logic [1:0] mode;
  logic [1:0] speed;

  int total = 0;
  int bad = 0;

  led_pattern_controller #(
    .TICK_DIV(TD), .DEBOUNCE_CYCLES(DB), .LED_W(8)
  ) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_mode(btn_mode),
    .btn_speed(btn_speed), .led(led), .running(running), .mode(mode), .speed(speed)
  );

  initial forever #5 clk = ~clk;

  // Reference model: state, step index into the mode's sequence, tick count.
  int m_st = IDLE;
  int m_mode = 0;
  int m_speed = 0;
  int m_cnt = 0;
  int m_k = 0;
  bit m_p[3];
  bit m_s0[3];
  bit m_s1[3];
  bit m_lvl[3];
  bit m_prev[3];
  int m_run[3];

  function automatic int seq_led(int md, int k);
    int p;
    case (md)
      0: return 1 << (k % 8);
      1: return 128 >> (k % 8);
      2: begin
        p = k % 14;
        return (p < 8) ? (1 << p) : (1 << (14 - p));
      end
      default: return (k % 2 == 0) ? 32'h55 : 32'hAA;
    endcase
  endfunction

  function automatic int exp_led();
    return (m_st == IDLE) ? 0 : seq_led(m_mode, m_k);
  endfunction

  task automatic model_reset();
    m_st = IDLE; m_mode = 0; m_speed = 0; m_cnt = 0; m_k = 0;
    for (int b = 0; b < 3; b++) begin
      m_p[b] = 0; m_s0[b] = 0; m_s1[b] = 0; m_lvl[b] = 0; m_prev[b] = 0; m_run[b] = 0;
    end
  endtask

  task automatic model_step();
    bit raw[3];
    bit np[3];
    bit syn;
    int div;
    bit last, tick, reload;
    raw[0] = btn_start; raw[1] = btn_mode; raw[2] = btn_speed;
    div = TD >> m_speed;
    last = (m_cnt == div - 1);
    tick = (m_st == RUN) && last && !m_p[1] && !m_p[2];
    reload = (m_st == IDLE && m_p[0]) || (m_st != IDLE && m_p[1]);
    if (m_st == IDLE || m_p[1] || m_p[2]) m_cnt = 0;
    else if (m_st == RUN) m_cnt = last ? 0 : m_cnt + 1;
    if (reload) m_k = 0;
    else if (tick) m_k = m_k + 1;
    m_mode = (m_mode + int'(m_p[1])) % 4;
    m_speed = (m_speed + int'(m_p[2])) % 4;
    if (m_p[0]) m_st = (m_st == RUN) ? PAUSE : RUN;
    // A level is accepted once DB consecutive synced samples agree on a new value.
    for (int b = 0; b < 3; b++) begin
      syn = m_s1[b];
      m_s1[b] = m_s0[b];
      m_s0[b] = raw[b];
      m_run[b] = (syn == m_prev[b]) ? m_run[b] + 1 : 1;
      m_prev[b] = syn;
      np[b] = 0;
      if (syn != m_lvl[b] && m_run[b] >= DB) begin
        m_lvl[b] = syn;
        np[b] = syn;
      end
    end
    m_p = np;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Literal LED expectation checked against both the DUT and the model.
  task automatic pin_led(input string name, input logic [7:0] want);
    check({name, "_dut"}, {24'h0, led}, {24'h0, want});
    check({name, "_model"}, exp_led(), {24'h0, want});
  endtask

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    check("cyc_led", {24'h0, led}, exp_led());
    check("cyc_running", {31'h0, running}, (m_st == RUN) ? 1 : 0);
    check("cyc_mode", {30'h0, mode}, m_mode);
    check("cyc_speed", {30'h0, speed}, m_speed);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(3);
    check("rst_led", {24'h0, led}, 0);
    check("rst_running", {31'h0, running}, 0);
    check("rst_mode", {30'h0, mode}, 0);
    check("rst_speed", {30'h0, speed}, 0);
    rst = 1'b1;
    cyc(2);

    // Start: one accepted press, SHL from 0x01, one step per 16 cycles.
    btn_start = 1'b1;
    cyc(7);
    check("start_running", {31'h0, running}, 1);
    pin_led("start_init", 8'h01);
    cyc(3); btn_start = 1'b0;
    cyc(12); pin_led("pre_tick", 8'h01);
    cyc(1);  pin_led("first_tick", 8'h02);
    cyc(111); pin_led("shl_top", 8'h80);
    cyc(1);   pin_led("shl_wrap", 8'h01);

    // Short glitch on start must be ignored.
    btn_start = 1'b1; cyc(2); btn_start = 1'b0;
    cyc(18);
    check("glitch_running", {31'h0, running}, 1);
    pin_led("glitch_led", 8'h02);

    // Two mode presses: SHR then BOUNCE.
    btn_mode = 1'b1; cyc(7);
    check("mode1", {30'h0, mode}, 1);
    pin_led("shr_init", 8'h80);
    btn_mode = 1'b0; cyc(8);
    btn_mode = 1'b1; cyc(7);
    check("mode2", {30'h0, mode}, 2);
    pin_led("bounce_init", 8'h01);
    btn_mode = 1'b0;
    cyc(16); pin_led("bounce_1", 8'h02);
    cyc(96); pin_led("bounce_7", 8'h80);
    cyc(16); pin_led("bounce_8", 8'h40);
    cyc(80); pin_led("bounce_13", 8'h02);
    cyc(16); pin_led("bounce_14", 8'h01);

    // Speed presses: 1, 2, 3 (div 2), then wrap to 0.
    btn_speed = 1'b1; cyc(7);
    check("speed1", {30'h0, speed}, 1);
    btn_speed = 1'b0; cyc(8);
    btn_speed = 1'b1; cyc(7);
    check("speed2", {30'h0, speed}, 2);
    btn_speed = 1'b0; cyc(8);
    btn_speed = 1'b1; cyc(7);
    check("speed3", {30'h0, speed}, 3);
    pin_led("speed3_led", 8'h10);
    btn_speed = 1'b0;
    cyc(2); pin_led("fast_1", 8'h20);
    cyc(2); pin_led("fast_2", 8'h40);
    cyc(4);
    btn_speed = 1'b1; cyc(7);
    check("speed_wrap", {30'h0, speed}, 0);
    pin_led("speed_wrap_led", 8'h08);
    btn_speed = 1'b0;

    // Pause at 0x08, hold, resume for the remaining count.
    btn_start = 1'b1; cyc(7);
    check("pause_running", {31'h0, running}, 0);
    pin_led("pause_led", 8'h08);
    cyc(3); btn_start = 1'b0;
    cyc(97);
    check("pause_hold_running", {31'h0, running}, 0);
    pin_led("pause_hold", 8'h08);
    btn_start = 1'b1; cyc(7);
    check("resume_running", {31'h0, running}, 1);
    pin_led("resume_led", 8'h08);
    cyc(3); btn_start = 1'b0;
    cyc(5); pin_led("resume_pre", 8'h08);
    cyc(1); pin_led("resume_step", 8'h04);

    // Mode and speed in the same cycle: BLINK at speed 1.
    btn_mode = 1'b1; btn_speed = 1'b1; cyc(7);
    check("blink_mode", {30'h0, mode}, 3);
    check("blink_speed", {30'h0, speed}, 1);
    pin_led("blink_init", 8'h55);
    cyc(3); btn_mode = 1'b0; btn_speed = 1'b0;
    cyc(5); pin_led("blink_b", 8'hAA);

    // Asynchronous reset mid-cycle.
    #2 rst = 1'b0;
    #1;
    pin_led("arst_led", 8'h00);
    check("arst_running", {31'h0, running}, 0);
    check("arst_mode", {30'h0, mode}, 0);
    check("arst_speed", {30'h0, speed}, 0);
    @(negedge clk);
    cyc(2); rst = 1'b1;
    cyc(20);
    check("post_rst_running", {31'h0, running}, 0);
    pin_led("post_rst_led", 8'h00);

    // Start and mode together from idle: run with SHR pattern.
    btn_start = 1'b1; btn_mode = 1'b1; cyc(7);
    check("combo_running", {31'h0, running}, 1);
    check("combo_mode", {30'h0, mode}, 1);
    pin_led("combo_led", 8'h80);
    btn_start = 1'b0; btn_mode = 1'b0;
    cyc(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
